// File: rtl/rr_mux_n_if.sv
// rr_mux_n_if: producer/consumer handshake bundle for rr_mux_n.
// s_i/so_i exist only when MUX_SEL_OVERRIDE_EN is defined.
interface rr_mux_n_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int CW = $clog2(N);
  logic [N*W-1:0] d_i;
  logic [N-1:0]   dv_i;
  logic [N-1:0]   dr_o;
  logic [W-1:0]   y_o;
  logic [CW-1:0]  ych_o;
  logic           yv_o;
  logic           yr_i;
`ifdef MUX_SEL_OVERRIDE_EN
  logic [CW-1:0]  s_i;
  logic           so_i;
  modport slave  (input d_i, dv_i, yr_i, s_i, so_i, output dr_o, y_o, ych_o, yv_o);
  modport master (output d_i, dv_i, yr_i, s_i, so_i, input dr_o, y_o, ych_o, yv_o);
`else
  modport slave  (input d_i, dv_i, yr_i, output dr_o, y_o, ych_o, yv_o);
  modport master (output d_i, dv_i, yr_i, input dr_o, y_o, ych_o, yv_o);
`endif
endinterface

// File: rtl/rr_mux_n.sv
// rr_mux_n: N-channel round-robin valid/ready mux with a one-entry registered output and channel tag.
// Optional feature: define MUX_SEL_OVERRIDE_EN to add the s_i/so_i forced-select inputs.
module rr_mux_n #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int CW = $clog2(N)
) (
  input logic      clk,
  input logic      rst,
  rr_mux_n_if.slave bus
);
  logic [CW-1:0] ptr_q, ptr_d, ych_q, g;
  logic [W-1:0]  y_q, y_d;
  logic          yv_q, hit, ld, ovr;
  logic [N-1:0]  dr;
  logic [CW:0]   idx;
  // rst gates ld so no ready can leak out while the block is held in reset
  assign ld = !rst && (!yv_q || bus.yr_i);
`ifdef MUX_SEL_OVERRIDE_EN
  assign ovr = bus.so_i;
`else
  assign ovr = 1'b0;
`endif
  always_comb begin
    g = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (CW+1)'(k);
      idx = idx >= (CW+1)'(N) ? idx - (CW+1)'(N) : idx;
      if (!hit && !ovr && bus.dv_i[idx[CW-1:0]]) begin
        hit = 1'b1;
        g = idx[CW-1:0];
      end
`ifdef MUX_SEL_OVERRIDE_EN
      if (ovr && bus.s_i == CW'(k) && bus.dv_i[k]) begin
        hit = 1'b1;
        g = CW'(k);
      end
`endif
    end
  end
  always_comb begin
    y_d = '0;
    dr = '0;
    for (int k = 0; k < N; k++) begin
      if (g == CW'(k)) y_d = bus.d_i[k*W +: W];
      dr[k] = hit && ld && g == CW'(k);
    end
    ptr_d = (hit && !ovr) ? (g == CW'(N-1) ? '0 : g + CW'(1)) : ptr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      y_q <= '0;
      ych_q <= '0;
      yv_q <= 1'b0;
      ptr_q <= '0;
    end else if (ld) begin
      yv_q <= hit;
      if (hit) begin
        y_q <= y_d;
        ych_q <= g;
        ptr_q <= ptr_d;
      end
    end
  assign bus.dr_o = dr;
  assign bus.y_o = y_q;
  assign bus.ych_o = ych_q;
  assign bus.yv_o = yv_q;
endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: directed scenarios plus randomized traffic checked every cycle against a behavioural model.
module tb_rr_mux_n;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vec = 0;
  int bad = 0;
  rr_mux_n_if #(.N(N), .W(W)) bus ();
  rr_mux_n #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  int m_ptr = 0;
  int m_ych = 0;
  int m_xfer = -1;
  int mg;
  bit m_yv = 1'b0;
  logic [W-1:0] m_y = '0;
  function automatic bit ovr();
`ifdef MUX_SEL_OVERRIDE_EN
    return bus.so_i;
`else
    return 1'b0;
`endif
  endfunction
  // first valid channel in search order starting at the pointer, -1 if none
  function automatic int grant();
    logic [N-1:0] v = bus.dv_i;
`ifdef MUX_SEL_OVERRIDE_EN
    if (bus.so_i) return (int'(bus.s_i) < N && v[bus.s_i]) ? int'(bus.s_i) : -1;
`endif
    for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction
  always_comb mg = grant();
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_ptr <= 0;
      m_y <= '0;
      m_ych <= 0;
      m_yv <= 1'b0;
      m_xfer <= -1;
    end else begin
      m_xfer <= -1;
      if (!m_yv || bus.yr_i) begin
        m_yv <= mg >= 0;
        if (mg >= 0) begin
          m_y <= bus.d_i[mg*W +: W];
          m_ych <= mg;
          m_xfer <= mg;
          if (!ovr()) m_ptr <= (mg + 1) % N;
        end
      end
    end
  always @(negedge clk)
    if (!rst) begin : cmp
      logic [N-1:0] e;
      e = '0;
      if ((!m_yv || bus.yr_i) && mg >= 0) e[mg] = 1'b1;
      chk("model_dr", 32'(bus.dr_o), 32'(e));
      chk("model_yv", 32'(bus.yv_o), 32'(m_yv));
      chk("model_y", 32'(bus.y_o), 32'(m_y));
      chk("model_ych", 32'(bus.ych_o), 32'(m_ych));
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.d_i = '0;
    bus.dv_i = '1;
    bus.yr_i = 1'b1;
`ifdef MUX_SEL_OVERRIDE_EN
    bus.s_i = '0;
    bus.so_i = 1'b0;
`endif
    #12;
    chk("rst_dr", 32'(bus.dr_o), 0);
    chk("rst_yv", 32'(bus.yv_o), 0);
    chk("rst_y", 32'(bus.y_o), 0);
    chk("rst_ych", 32'(bus.ych_o), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) bus.d_i[i*W +: W] = W'(8'h10 + i);
    #1 chk("rr_first_dr", 32'(bus.dr_o), 32'h1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_ych", 32'(bus.ych_o), 32'(k % 4));
      chk("rr_y", 32'(bus.y_o), 32'(8'h10 + k % 4));
      chk("rr_yv", 32'(bus.yv_o), 1);
    end
    bus.dv_i = 4'b0010;
    bus.d_i[1*W +: W] = 8'h11;
    tick();
    chk("bp_load_y", 32'(bus.y_o), 32'h11);
    bus.yr_i = 1'b0;
    bus.dv_i = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_dr", 32'(bus.dr_o), 0);
      tick();
      chk("bp_hold_y", 32'(bus.y_o), 32'h11);
      chk("bp_hold_yv", 32'(bus.yv_o), 1);
    end
    bus.yr_i = 1'b1;
    #1 chk("bp_release_dr", 32'(bus.dr_o), 32'b0100);
    tick();
    chk("bp_next_ych", 32'(bus.ych_o), 2);
    chk("bp_next_y", 32'(bus.y_o), 32'h12);
    bus.dv_i = 4'b0010;
    tick();
    chk("sp_pre_ych", 32'(bus.ych_o), 1);
    bus.dv_i = 4'b1010;
    #1 chk("sp_dr3", 32'(bus.dr_o), 32'b1000);
    tick();
    chk("sp_ych3", 32'(bus.ych_o), 3);
    bus.dv_i = 4'b0010;
    tick();
    chk("sp_ych1", 32'(bus.ych_o), 1);
    bus.dv_i = 4'b1111;
    #1 chk("sp_ptr2_dr", 32'(bus.dr_o), 32'b0100);
    bus.dv_i = 4'b0100;
    tick();
    chk("idle_ych", 32'(bus.ych_o), 2);
    chk("idle_yv1", 32'(bus.yv_o), 1);
    bus.dv_i = '0;
    #1 chk("idle_dr", 32'(bus.dr_o), 0);
    tick();
    chk("idle_yv0", 32'(bus.yv_o), 0);
    chk("idle_y_hold", 32'(bus.y_o), 32'h12);
    chk("idle_ych_hold", 32'(bus.ych_o), 2);
    tick();
    chk("idle_yv0b", 32'(bus.yv_o), 0);
    bus.dv_i = 4'b0001;
    bus.d_i[0*W +: W] = 8'h5A;
    bus.yr_i = 1'b0;
    tick();
    chk("ar_pre_y", 32'(bus.y_o), 32'h5A);
    chk("ar_pre_yv", 32'(bus.yv_o), 1);
    #3;
    bus.dv_i = 4'b1111;
    rst = 1'b1;
    #1;
    chk("ar_y", 32'(bus.y_o), 0);
    chk("ar_yv", 32'(bus.yv_o), 0);
    chk("ar_ych", 32'(bus.ych_o), 0);
    chk("ar_dr", 32'(bus.dr_o), 0);
    bus.yr_i = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("ar_first_dr", 32'(bus.dr_o), 32'b0001);
    tick();
    chk("ar_first_ych", 32'(bus.ych_o), 0);
    chk("ar_first_y", 32'(bus.y_o), 32'h5A);
`ifdef MUX_SEL_OVERRIDE_EN
    bus.so_i = 1'b1;
    bus.s_i = 2'd2;
    #1 chk("ov_dr", 32'(bus.dr_o), 32'b0100);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ov_ych", 32'(bus.ych_o), 2);
    end
    bus.so_i = 1'b0;
    #1 chk("ov_resume_dr", 32'(bus.dr_o), 32'b0010);
    tick();
    chk("ov_resume_ych", 32'(bus.ych_o), 1);
`endif
    for (int c = 0; c < 800; c++) begin
      bus.yr_i = $urandom_range(0, 3) != 0;
`ifdef MUX_SEL_OVERRIDE_EN
      bus.so_i = $urandom_range(0, 3) == 0;
      bus.s_i = 2'($urandom_range(0, N - 1));
`endif
      for (int i = 0; i < N; i++)
        if (!(bus.dv_i[i] && m_xfer != i)) begin
          bus.dv_i[i] = $urandom_range(0, 2) != 0;
          bus.d_i[i*W +: W] = W'($urandom);
        end
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
